// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX bundle in, EX/MEM bundle and fetch redirect out.
interface ex_stage_if;
   logic        valid_i;
   logic [31:0] pc_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [31:0] imm_i;
   logic [3:0]  alu_op_i;
   logic        a_sel_i;
   logic        b_sel_i;
   logic [1:0]  fwd_a_i;
   logic [1:0]  fwd_b_i;
   logic [31:0] fwd_mem_i;
   logic [31:0] fwd_wb_i;
   logic        is_branch_i;
   logic        is_jal_i;
   logic        is_jalr_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_addr_i;
   logic        rd_wen_i;
   logic        stall_i;
   logic        flush_i;
   logic        ex_valid_o;
   logic [31:0] ex_result_o;
   logic [31:0] ex_store_data_o;
   logic [4:0]  ex_rd_addr_o;
   logic        ex_rd_wen_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   modport master (
      output valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i, alu_op_i, a_sel_i, b_sel_i,
             fwd_a_i, fwd_b_i, fwd_mem_i, fwd_wb_i, is_branch_i, is_jal_i, is_jalr_i,
             funct3_i, rd_addr_i, rd_wen_i, stall_i, flush_i,
      input  ex_valid_o, ex_result_o, ex_store_data_o, ex_rd_addr_o, ex_rd_wen_o,
             redirect_o, redirect_pc_o
   );
   modport slave (
      input  valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i, alu_op_i, a_sel_i, b_sel_i,
             fwd_a_i, fwd_b_i, fwd_mem_i, fwd_wb_i, is_branch_i, is_jal_i, is_jalr_i,
             funct3_i, rd_addr_i, rd_wen_i, stall_i, flush_i,
      output ex_valid_o, ex_result_o, ex_store_data_o, ex_rd_addr_o, ex_rd_wen_o,
             redirect_o, redirect_pc_o
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with forwarding, ALU, branch resolution and EX/MEM register.
module ex_stage (
   input logic       clk,
   input logic       rst_n,
   ex_stage_if.slave bus
);
   logic [31:0] fa, fb, a, b, alu, result, target;
   logic [32:0] diff, bdiff;
   logic        slt, beq, blt, bltu, cond, jump, taken;
   always_comb begin
      fa = bus.fwd_a_i == 2'b01 ? bus.fwd_mem_i : bus.fwd_a_i == 2'b10 ? bus.fwd_wb_i : bus.rs1_data_i;
      fb = bus.fwd_b_i == 2'b01 ? bus.fwd_mem_i : bus.fwd_b_i == 2'b10 ? bus.fwd_wb_i : bus.rs2_data_i;
      a = bus.a_sel_i ? bus.pc_i : fa;
      b = bus.b_sel_i ? bus.imm_i : fb;
      diff = {1'b0, a} - {1'b0, b};
      slt = (a[31] ^ b[31]) ? a[31] : diff[31];
      case (bus.alu_op_i)
         4'd0:    alu = diff[31:0] + b + b;
         4'd1:    alu = diff[31:0];
         4'd2:    alu = a << b[4:0];
         4'd3:    alu = {31'd0, slt};
         4'd4:    alu = {31'd0, diff[32]};
         4'd5:    alu = a ^ b;
         4'd6:    alu = a >> b[4:0];
         4'd7:    alu = $signed(a) >>> b[4:0];
         4'd8:    alu = a | b;
         4'd9:    alu = a & b;
         4'd10:   alu = b;
         default: alu = 32'd0;
      endcase
   end
   // Branch compare always works on the forwarded registers, never the ALU operands.
   always_comb begin
      bdiff = {1'b0, fa} - {1'b0, fb};
      beq = fa == fb;
      blt = (fa[31] ^ fb[31]) ? fa[31] : bdiff[31];
      bltu = bdiff[32];
      cond = bus.funct3_i == 3'b000 ? beq :
             bus.funct3_i == 3'b001 ? !beq :
             bus.funct3_i == 3'b100 ? blt :
             bus.funct3_i == 3'b101 ? !blt :
             bus.funct3_i == 3'b110 ? bltu :
             bus.funct3_i == 3'b111 ? !bltu : 1'b0;
      jump = bus.is_jal_i | bus.is_jalr_i;
      taken = bus.valid_i & (jump | (bus.is_branch_i & cond));
      target = bus.is_jalr_i ? ((fa + bus.imm_i) & ~32'd1) : bus.pc_i + bus.imm_i;
      result = jump ? bus.pc_i + 32'd4 : alu;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ex_valid_o      <= 1'b0;
         bus.ex_result_o     <= 32'd0;
         bus.ex_store_data_o <= 32'd0;
         bus.ex_rd_addr_o    <= 5'd0;
         bus.ex_rd_wen_o     <= 1'b0;
         bus.redirect_o      <= 1'b0;
         bus.redirect_pc_o   <= 32'd0;
      end else if (bus.flush_i) begin
         bus.ex_valid_o  <= 1'b0;
         bus.ex_rd_wen_o <= 1'b0;
         bus.redirect_o  <= 1'b0;
      end else if (bus.stall_i) begin
         bus.redirect_o <= 1'b0;
      end else begin
         bus.ex_valid_o      <= bus.valid_i;
         bus.ex_result_o     <= result;
         bus.ex_store_data_o <= fb;
         bus.ex_rd_addr_o    <= bus.rd_addr_i;
         bus.ex_rd_wen_o     <= bus.rd_wen_i & bus.valid_i;
         bus.redirect_o      <= taken;
         bus.redirect_pc_o   <= target;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic        ev, ew, er, known;
   logic [31:0] eres, esd, erpc;
   logic [4:0]  erd;
   ex_stage_if bus ();
   ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x << y[4:0];
         4'd3:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd4:    return (x < y) ? 32'd1 : 32'd0;
         4'd5:    return x ^ y;
         4'd6:    return x >> y[4:0];
         4'd7:    return $signed(x) >>> y[4:0];
         4'd8:    return x | y;
         4'd9:    return x & y;
         4'd10:   return y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
      case (f3)
         3'b000:  return x == y;
         3'b001:  return x != y;
         3'b100:  return $signed(x) < $signed(y);
         3'b101:  return $signed(x) >= $signed(y);
         3'b110:  return x < y;
         3'b111:  return x >= y;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
      return s == 2'b01 ? bus.fwd_mem_i : s == 2'b10 ? bus.fwd_wb_i : r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ev = 0; ew = 0; er = 0; known = 1; eres = 0; esd = 0; erd = 0; erpc = 0;
   endtask

   task automatic model_edge();
      logic [31:0] fa, fb;
      fa = pick(bus.fwd_a_i, bus.rs1_data_i);
      fb = pick(bus.fwd_b_i, bus.rs2_data_i);
      if (bus.flush_i) begin
         ev = 0; ew = 0; er = 0; known = 0;
      end else if (bus.stall_i) begin
         er = 0;
      end else begin
         ev = bus.valid_i;
         ew = bus.valid_i & bus.rd_wen_i;
         er = bus.valid_i & (bus.is_jal_i | bus.is_jalr_i | (bus.is_branch_i & ref_cond(bus.funct3_i, fa, fb)));
         eres = (bus.is_jal_i | bus.is_jalr_i) ? bus.pc_i + 4 :
                ref_alu(bus.alu_op_i, bus.a_sel_i ? bus.pc_i : fa, bus.b_sel_i ? bus.imm_i : fb);
         esd = fb;
         erd = bus.rd_addr_i;
         erpc = bus.is_jalr_i ? {fa[31:1] + bus.imm_i[31:1] + {30'd0, (fa[0] & bus.imm_i[0])}, 1'b0} : bus.pc_i + bus.imm_i;
         known = 1;
      end
   endtask

   task automatic check_all();
      chk("valid", {31'd0, bus.ex_valid_o}, {31'd0, ev});
      chk("rd_wen", {31'd0, bus.ex_rd_wen_o}, {31'd0, ew});
      chk("redirect", {31'd0, bus.redirect_o}, {31'd0, er});
      if (known) begin
         chk("result", bus.ex_result_o, eres);
         chk("store_data", bus.ex_store_data_o, esd);
         chk("rd_addr", {27'd0, bus.ex_rd_addr_o}, {27'd0, erd});
      end
      if (er) chk("redirect_pc", bus.redirect_pc_o, erpc);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      bus.valid_i = 1; bus.pc_i = 32'h100; bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.imm_i = 0;
      bus.alu_op_i = 0; bus.a_sel_i = 0; bus.b_sel_i = 0; bus.fwd_a_i = 0; bus.fwd_b_i = 0;
      bus.fwd_mem_i = 0; bus.fwd_wb_i = 0; bus.is_branch_i = 0; bus.is_jal_i = 0; bus.is_jalr_i = 0;
      bus.funct3_i = 0; bus.rd_addr_i = 5'd3; bus.rd_wen_i = 1; bus.stall_i = 0; bus.flush_i = 0;
   endtask

   task automatic alu_case(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op, input logic [31:0] exp);
      idle();
      bus.rs1_data_i = x; bus.rs2_data_i = y; bus.alu_op_i = op;
      tick();
      chk(tag, bus.ex_result_o, exp);
   endtask

   initial begin
      idle();
      model_reset();
      #3;
      check_all();
      chk("reset_rpc", bus.redirect_pc_o, 32'd0);
      #9 rst_n = 1;
      // signed/unsigned compare corners
      alu_case("slt_neg", 32'hFFFFFFFF, 32'd1, 4'd3, 32'd1);
      alu_case("sltu_neg", 32'hFFFFFFFF, 32'd1, 4'd4, 32'd0);
      alu_case("slt_min", 32'h80000000, 32'h7FFFFFFF, 4'd3, 32'd1);
      alu_case("slt_eq", 32'd5, 32'd5, 4'd3, 32'd0);
      alu_case("sltu_eq", 32'd5, 32'd5, 4'd4, 32'd0);
      alu_case("sra", 32'h80000000, 32'd4, 4'd7, 32'hF8000000);
      alu_case("op_15", 32'd7, 32'd9, 4'd15, 32'd0);
      for (int s = 0; s < 4; s++) begin
         idle();
         bus.rs1_data_i = 1; bus.fwd_mem_i = 10; bus.fwd_wb_i = 20; bus.imm_i = 3; bus.b_sel_i = 1;
         bus.fwd_a_i = 2'(s);
         tick();
         chk("fwd_a", bus.ex_result_o, s == 1 ? 32'd13 : s == 2 ? 32'd23 : 32'd4);
      end
      idle();
      bus.is_branch_i = 1; bus.funct3_i = 3'b110; bus.rs1_data_i = 32'hFFFFFFF0; bus.rs2_data_i = 1;
      bus.pc_i = 32'h200; bus.imm_i = 32'h40; bus.rd_wen_i = 0;
      tick();
      chk("bltu_nt", {31'd0, bus.redirect_o}, 32'd0);
      bus.funct3_i = 3'b100;
      tick();
      chk("blt_t", {31'd0, bus.redirect_o}, 32'd1);
      chk("blt_pc", bus.redirect_pc_o, 32'h240);
      bus.funct3_i = 3'b010; bus.rs2_data_i = 32'hFFFFFFF0;
      tick();
      chk("f3_010", {31'd0, bus.redirect_o}, 32'd0);
      idle();
      bus.is_jalr_i = 1; bus.rs1_data_i = 32'h1001; bus.imm_i = 2; bus.alu_op_i = 4'd9;
      tick();
      chk("jalr_pc", bus.redirect_pc_o, 32'h1002);
      chk("jalr_res", bus.ex_result_o, 32'h104);
      chk("jalr_redir", {31'd0, bus.redirect_o}, 32'd1);
      idle();
      bus.valid_i = 0;
      tick();
      chk("jalr_pulse", {31'd0, bus.redirect_o}, 32'd0);
      idle();
      bus.is_branch_i = 1; bus.funct3_i = 3'b000; bus.rs1_data_i = 7; bus.rs2_data_i = 7;
      bus.imm_i = 32'hFFFFFFF8; bus.pc_i = 32'h300;
      tick();
      chk("beq_t", {31'd0, bus.redirect_o}, 32'd1);
      bus.stall_i = 1; bus.rs1_data_i = 1; bus.pc_i = 32'h900;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_redir", {31'd0, bus.redirect_o}, 32'd0);
         chk("stall_valid", {31'd0, bus.ex_valid_o}, 32'd1);
         chk("stall_res", bus.ex_result_o, 32'd14);
      end
      bus.flush_i = 1;
      tick();
      chk("flush_stall", {31'd0, bus.ex_valid_o}, 32'd0);
      idle();
      bus.is_jal_i = 1; bus.imm_i = 32'h20;
      tick();
      bus.stall_i = 1;
      tick();
      #2 rst_n = 0;
      #1;
      chk("rst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
      chk("rst_res", bus.ex_result_o, 32'd0);
      chk("rst_sd", bus.ex_store_data_o, 32'd0);
      chk("rst_rd", {27'd0, bus.ex_rd_addr_o}, 32'd0);
      chk("rst_wen", {31'd0, bus.ex_rd_wen_o}, 32'd0);
      chk("rst_redir", {31'd0, bus.redirect_o}, 32'd0);
      chk("rst_rpc", bus.redirect_pc_o, 32'd0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1;
      tick();
      bus.stall_i = 0;
      for (int i = 0; i < 300; i++) begin
         int cls;
         cls = $urandom_range(0, 3);
         bus.valid_i = ($urandom_range(0, 7) != 0);
         bus.pc_i = $urandom & 32'hFFFFFFFC;
         bus.rs1_data_i = $urandom;
         bus.rs2_data_i = ($urandom_range(0, 3) == 0) ? bus.rs1_data_i : $urandom;
         bus.imm_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
         bus.alu_op_i = 4'($urandom_range(0, 15));
         bus.a_sel_i = 1'($urandom);
         bus.b_sel_i = 1'($urandom);
         bus.fwd_a_i = 2'($urandom);
         bus.fwd_b_i = 2'($urandom);
         bus.fwd_mem_i = $urandom;
         bus.fwd_wb_i = $urandom;
         bus.is_branch_i = cls == 1;
         bus.is_jal_i = cls == 2;
         bus.is_jalr_i = cls == 3;
         bus.funct3_i = 3'($urandom);
         bus.rd_addr_i = 5'($urandom);
         bus.rd_wen_i = 1'($urandom);
         bus.stall_i = ($urandom_range(0, 7) == 0);
         bus.flush_i = ($urandom_range(0, 7) == 0);
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline. Takes the ID/EX bundle, resolves operand forwarding, and performs the ALU operation (including signed/unsigned set-less-than). It also evaluates branch/jump conditions and registers the result into the EX/MEM boundary. It feeds the MEM stage and returns a one-cycle redirect to the fetch stage.

## Interface
- Parameters: none (XLEN fixed at 32).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  ID/EX holds a real instruction.
- `pc_i`  in  32  instruction PC.
- `rs1_data_i`, `rs2_data_i`  in  32 each  register-file read data.
- `imm_i`  in  32  sign-extended immediate.
- `alu_op_i`  in  4  operation code; encodings under Operation.
- `a_sel_i`  in  1  ALU A source: 0 = forwarded rs1, 1 = `pc_i`.
- `b_sel_i`  in  1  ALU B source: 0 = forwarded rs2, 1 = `imm_i`.
- `fwd_a_i`, `fwd_b_i`  in  2 each  forwarding select: 00 = register data, 01 = `fwd_mem_i`, 10 = `fwd_wb_i`, 11 = register data.
- `fwd_mem_i`, `fwd_wb_i`  in  32 each  bypass values.
- `is_branch_i`, `is_jal_i`, `is_jalr_i`  in  1 each  control-flow class.
- `funct3_i`  in  3  branch condition.
- `rd_addr_i`  in  5  destination register.
- `rd_wen_i`  in  1  destination write enable.
- `stall_i`  in  1  hold the EX/MEM register.
- `flush_i`  in  1  kill the instruction entering EX/MEM.
- `ex_valid_o`  out  1  EX/MEM valid.
- `ex_result_o`  out  32  ALU result, or PC+4 for jumps.
- `ex_store_data_o`  out  32  forwarded rs2 value.
- `ex_rd_addr_o`  out  5  destination register.
- `ex_rd_wen_o`  out  1  gated by valid.
- `redirect_o`  out  1  one-cycle fetch redirect pulse.
- `redirect_pc_o`  out  32  redirect target.

## Operation
- Forwarding:
  - Forwarded rs1 (`fa`) and forwarded rs2 (`fb`) are selected per `fwd_a_i` and `fwd_b_i`.
  - Branch comparison and `ex_store_data_o` always use `fa` and `fb`, never `imm_i` or `pc_i`.
- ALU ops (all results 32 bits, wrap modulo 2^32):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI).
  - Codes 11–15 produce 0.
  - Shift amount is B[4:0].
- SLT: A and B signed. If the signs differ, result = A[31]; otherwise result = sign bit of A−B. Result is zero-extended.
- SLTU: result = 1 when the borrow of A−B is set, i.e. A < B unsigned.
- Branch condition on `fa`/`fb`:
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010 and 011 are never taken.
- Targets:
  - Branch and JAL: `pc_i + imm_i`.
  - JALR: `(fa + imm_i) & ~1`.
  - For JAL and JALR, the result is `pc_i + 4` regardless of `alu_op_i`.
- Taken = `valid_i` & (JAL | JALR | (branch & condition true)).
- Register update, in priority order:
  - `flush_i`: `ex_valid_o`, `ex_rd_wen_o` and `redirect_o` go to 0; data fields may take any value.
  - `stall_i` (no flush): every field holds, except `redirect_o`, which goes to 0.
  - Otherwise: capture all fields; `ex_rd_wen_o` = `rd_wen_i & valid_i`; `redirect_o` = taken.
- The redirect fires once per instruction. A held (stalled) instruction never re-issues a redirect.

## Timing
- Reset (asynchronous, immediate on `rst_n` low): every output is 0, including `redirect_pc_o`. The first capture is on the first rising edge after `rst_n` goes high.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- `redirect_o` is high for exactly one cycle, coincident with the jump/branch on `ex_valid_o`. The upstream hazard unit must flush IF/ID and ID/EX in that cycle; this block does not flush itself.
- `flush_i` and `stall_i` high together: flush wins.
- Reset asserted mid-stall clears the held instruction; no redirect follows.
- No combinational path from any input to any output.

## Test plan
- SLT/SLTU signs:
  - A=0xFFFFFFFF, B=0x00000001, op 3 → result 1.
  - Same operands, op 4 → 0.
  - A=0x80000000, B=0x7FFFFFFF, op 3 → 1.
  - A=5, B=5, ops 3 and 4 → 0.
- Forwarding: `rs1_data_i`=1, `fwd_mem_i`=10, `fwd_wb_i`=20, B=imm 3, ADD. `fwd_a_i` 00/01/10/11 → results 4, 13, 23, 4.
- Branches:
  - BLTU with fa=0xFFFFFFF0, fb=1 → not taken.
  - BLT, same operands → taken, `redirect_pc_o` = pc+imm.
  - funct3 010 → never taken.
- JALR: fa=0x1001, imm=2, pc=0x100 → redirect_pc 0x1002, result 0x104, `redirect_o` high for one cycle.
- Stall/flush:
  - Taken branch followed by 3 stall cycles → outputs held, redirect pulses once.
  - Flush and stall asserted together → `ex_valid_o` = 0.
- Reset: assert `rst_n` low asynchronously mid-stall → all outputs 0 before the next edge.
